insa_alu_ext: RTL

Parametrised successor to the INSA-extended ALU. Integer ALU with a valid/ready issue port, a registered result port, and a multi-cycle buffer-read path to the external INSA buffer; the buffer has variable latency, multiple read channels and a timeout. It also holds the crash-enable flag and the buffer-reset pulse. Sits in the execute stage in place of the single-cycle ALU.

---
 rtl/insa_pkg.sv | 49 ++++
 rtl/insa_alu_core.sv | 79 +++++++
 rtl/insa_alu_ext.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/insa_pkg.sv
// Shared types for the INSA-extended ALU.
//   alu_ext_op_e     : operation encoding on op_i (integer ops plus BUFRD,
//                      RSTBUF and ENCRASH)
//   insa_alu_state_e : sequencing states of insa_alu_ext
//   ch_width()       : width of a channel-select field for a channel count
package insa_pkg;

   typedef enum logic [4:0] {
      OP_ADD,
      OP_SUB,
      OP_ADDW,
      OP_SUBW,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SLL,
      OP_SRL,
      OP_SRA,
      OP_SLLW,
      OP_SRLW,
      OP_SRAW,
      OP_SLTS,
      OP_SLTU,
      OP_EQ,
      OP_NE,
      OP_LTS,
      OP_LTU,
      OP_GES,
      OP_GEU,
      OP_BUFRD,
      OP_RSTBUF,
      OP_ENCRASH
   } alu_ext_op_e;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RESP
   } insa_alu_state_e;

   // Read data width of the external INSA buffer.
   localparam int BUF_DATA_W = 32;

   // A single channel still needs a 1-bit select field.
   function automatic int ch_width(input int num_ch);
      return (num_ch <= 1) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/insa_alu_core.sv
// Combinational datapath of the INSA-extended ALU.
// Ports:
//   op_i         operation
//   operand_a_i  rs1 value
//   operand_b_i  rs2 / immediate value
//   result_o     arithmetic / logic / shift / set-less-than result
//                (0 for branch ops, W-ops on a 32-bit datapath and the
//                buffer/control ops, which the top finishes itself)
//   branch_res_o comparison result for branch ops, 1 for every other op
module insa_alu_core
   import insa_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  alu_ext_op_e       op_i,
   input  logic [XLEN-1:0]   operand_a_i,
   input  logic [XLEN-1:0]   operand_b_i,
   output logic [XLEN-1:0]   result_o,
   output logic              branch_res_o
);

   localparam bit IS64 = (XLEN == 64);

   logic [5:0]  shamt;
   logic [4:0]  shamt_w;
   logic [31:0] a_w;
   logic [31:0] b_w;
   logic [31:0] word_res;
   logic        lt_s;
   logic        lt_u;
   logic        eq;

   always_comb begin
      // Full-width shifts use 6 bits only on a 64-bit datapath.
      shamt   = IS64 ? operand_b_i[5:0] : {1'b0, operand_b_i[4:0]};
      shamt_w = operand_b_i[4:0];
      a_w     = operand_a_i[31:0];
      b_w     = operand_b_i[31:0];
      lt_s    = $signed(operand_a_i) < $signed(operand_b_i);
      lt_u    = operand_a_i < operand_b_i;
      eq      = operand_a_i == operand_b_i;

      word_res = '0;
      case (op_i)
         OP_ADDW: word_res = a_w + b_w;
         OP_SUBW: word_res = a_w - b_w;
         OP_SLLW: word_res = a_w << shamt_w;
         OP_SRLW: word_res = a_w >> shamt_w;
         OP_SRAW: word_res = $signed(a_w) >>> shamt_w;
         default: word_res = '0;
      endcase

      result_o     = '0;
      branch_res_o = 1'b1;
      case (op_i)
         OP_ADD:  result_o = operand_a_i + operand_b_i;
         OP_SUB:  result_o = operand_a_i - operand_b_i;
         OP_AND:  result_o = operand_a_i & operand_b_i;
         OP_OR:   result_o = operand_a_i | operand_b_i;
         OP_XOR:  result_o = operand_a_i ^ operand_b_i;
         OP_SLL:  result_o = operand_a_i << shamt;
         OP_SRL:  result_o = operand_a_i >> shamt;
         OP_SRA:  result_o = $signed(operand_a_i) >>> shamt;
         // W-ops only exist on a 64-bit datapath; elsewhere they yield 0.
         OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW:
                  result_o = IS64 ? XLEN'($signed(word_res)) : '0;
         OP_SLTS: result_o = XLEN'(lt_s);
         OP_SLTU: result_o = XLEN'(lt_u);
         OP_EQ:   branch_res_o = eq;
         OP_NE:   branch_res_o = !eq;
         OP_LTS:  branch_res_o = lt_s;
         OP_LTU:  branch_res_o = lt_u;
         OP_GES:  branch_res_o = !lt_s;
         OP_GEU:  branch_res_o = !lt_u;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/insa_alu_ext.sv
// Execute-stage ALU with INSA buffer access.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   valid_i / ready_o       operation issue handshake
//   op_i, operand_a_i,
//   operand_b_i, imm_i,
//   ch_sel_i, trans_id_i    operation and its arguments
//   buf_req_o, buf_idx_o,
//   buf_ch_o                one-cycle buffer read request
//   buf_rvalid_i,
//   buf_rdata_i             buffer read return
//   valid_o / ready_i       result handshake
//   result_o, branch_res_o,
//   trans_id_o, err_o       registered response
//   rst_buf_o               one-cycle buffer reset pulse
//   en_crash_o              sticky crash-enable flag
module insa_alu_ext
   import insa_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int IDX_W         = 20,
   parameter int NUM_CH        = 2,
   parameter int TRANS_ID_BITS = 3,
   parameter int RD_TIMEOUT    = 15,
   localparam int CH_W         = ch_width(NUM_CH)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  alu_ext_op_e              op_i,
   input  logic [XLEN-1:0]          operand_a_i,
   input  logic [XLEN-1:0]          operand_b_i,
   input  logic [XLEN-1:0]          imm_i,
   input  logic [CH_W-1:0]          ch_sel_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   output logic                     buf_req_o,
   output logic [IDX_W-1:0]         buf_idx_o,
   output logic [CH_W-1:0]          buf_ch_o,
   input  logic                     buf_rvalid_i,
   input  logic [BUF_DATA_W-1:0]    buf_rdata_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [XLEN-1:0]          result_o,
   output logic                     branch_res_o,
   output logic [TRANS_ID_BITS-1:0] trans_id_o,
   output logic                     err_o,
   output logic                     rst_buf_o,
   output logic                     en_crash_o
);

   localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

   insa_alu_state_e          state_q,    state_d;
   logic                     valid_q,    valid_d;
   logic [XLEN-1:0]          result_q,   result_d;
   logic                     branch_q,   branch_d;
   logic [TRANS_ID_BITS-1:0] tid_q,      tid_d;
   logic                     err_q,      err_d;
   logic                     buf_req_q,  buf_req_d;
   logic [IDX_W-1:0]         buf_idx_q,  buf_idx_d;
   logic [CH_W-1:0]          buf_ch_q,   buf_ch_d;
   logic                     rst_buf_q,  rst_buf_d;
   logic                     en_crash_q, en_crash_d;
   logic [CNT_W-1:0]         cnt_q,      cnt_d;

   logic [XLEN-1:0] core_result;
   logic            core_branch;
   logic            accept;
   logic            ch_ok;
   logic            unused_imm;

   insa_alu_core #(
      .XLEN (XLEN)
   ) u_core (
      .op_i         (op_i),
      .operand_a_i  (operand_a_i),
      .operand_b_i  (operand_b_i),
      .result_o     (core_result),
      .branch_res_o (core_branch)
   );

   // Only the low IDX_W bits of the immediate address the buffer.
   assign unused_imm = ^imm_i[XLEN-1:IDX_W];

   // valid_o is high exactly while in RESP, so the result register is free
   // in IDLE and frees up in RESP in the same cycle the consumer drains it.
   assign ready_o = (state_q == IDLE) || ((state_q == RESP) && ready_i);
   assign accept  = valid_i && ready_o;
   assign ch_ok   = int'(ch_sel_i) < NUM_CH;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      result_d   = result_q;
      branch_d   = branch_q;
      tid_d      = tid_q;
      err_d      = err_q;
      buf_req_d  = 1'b0;
      buf_idx_d  = buf_idx_q;
      buf_ch_d   = buf_ch_q;
      rst_buf_d  = 1'b0;
      en_crash_d = en_crash_q;
      cnt_d      = cnt_q;

      case (state_q)
         IDLE, RESP: begin
            if ((state_q == RESP) && ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
            if (accept) begin
               tid_d    = trans_id_i;
               branch_d = core_branch;
               err_d    = 1'b0;
               result_d = '0;
               valid_d  = 1'b1;
               state_d  = RESP;
               case (op_i)
                  OP_BUFRD: begin
                     if (ch_ok) begin
                        buf_req_d = 1'b1;
                        buf_idx_d = imm_i[IDX_W-1:0];
                        buf_ch_d  = ch_sel_i;
                        cnt_d     = '0;
                        valid_d   = 1'b0;
                        state_d   = RD_WAIT;
                     end else begin
                        // Nonexistent channel: answer immediately with an error.
                        err_d = 1'b1;
                     end
                  end
                  OP_RSTBUF:  rst_buf_d = 1'b1;
                  OP_ENCRASH: begin
                     en_crash_d = 1'b1;
                     result_d   = XLEN'(1);
                  end
                  default:    result_d = core_result;
               endcase
            end
         end

         RD_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // Data arriving on the last allowed cycle still beats the timeout.
            if (buf_rvalid_i) begin
               result_d = XLEN'(buf_rdata_i);
               err_d    = 1'b0;
               valid_d  = 1'b1;
               state_d  = RESP;
            end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               valid_d  = 1'b1;
               state_d  = RESP;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         result_q   <= '0;
         branch_q   <= 1'b0;
         tid_q      <= '0;
         err_q      <= 1'b0;
         buf_req_q  <= 1'b0;
         buf_idx_q  <= '0;
         buf_ch_q   <= '0;
         rst_buf_q  <= 1'b0;
         en_crash_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         result_q   <= result_d;
         branch_q   <= branch_d;
         tid_q      <= tid_d;
         err_q      <= err_d;
         buf_req_q  <= buf_req_d;
         buf_idx_q  <= buf_idx_d;
         buf_ch_q   <= buf_ch_d;
         rst_buf_q  <= rst_buf_d;
         en_crash_q <= en_crash_d;
         cnt_q      <= cnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign result_o     = result_q;
   assign branch_res_o = branch_q;
   assign trans_id_o   = tid_q;
   assign err_o        = err_q;
   assign buf_req_o    = buf_req_q;
   assign buf_idx_o    = buf_idx_q;
   assign buf_ch_o     = buf_ch_q;
   assign rst_buf_o    = rst_buf_q;
   assign en_crash_o   = en_crash_q;

endmodule
